// File: rtl/step_position_tracker.sv
// ---------------------------------------------------------------------------
// step_position_tracker
//
// Tracks a stepper motor's position by counting step pulses from the motor
// driver, and runs a homing sequence that zeroes the position when the
// debounced home switch closes. A driver fault or a homing timeout latches
// the block into FAULT until software clears it.
//
// Ports
//   clk_100MHz  in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   mtr_step    in   step pulse (synchronous), one count per rising transition
//   mtr_dir     in   direction: 0 = increment, 1 = decrement (synchronous)
//   mtr_nhome   in   home switch, active-low, asynchronous
//   mtr_nflt    in   driver fault, active-low, asynchronous
//   home_req    in   single-cycle request to start a homing seek
//   clr_flt     in   single-cycle fault-clear request
//   pos         out  signed two's-complement step position (wraps)
//   homed       out  position is referenced to home
//   home_done   out  one-cycle pulse on homing success
//   flt         out  latched fault
//   home_to     out  latched homing timeout
//   state       out  FSM state: IDLE=0, SEEK=1, TRACK=2, FAULT=3
// ---------------------------------------------------------------------------
module step_position_tracker #(
   parameter int POS_W          = 24,
   parameter int DEBOUNCE       = 1000,
   parameter int HOME_MAX_STEPS = 200000
) (
   input  logic             clk_100MHz,
   input  logic             rst,
   input  logic             mtr_step,
   input  logic             mtr_dir,
   input  logic             mtr_nhome,
   input  logic             mtr_nflt,
   input  logic             home_req,
   input  logic             clr_flt,
   output logic [POS_W-1:0] pos,
   output logic             homed,
   output logic             home_done,
   output logic             flt,
   output logic             home_to,
   output logic [1:0]       state
);

   localparam int DB_W   = $clog2(DEBOUNCE + 1);
   localparam int SEEK_W = $clog2(HOME_MAX_STEPS + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE - 1);
   localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
   localparam logic [SEEK_W-1:0] SEEK_MAX  = SEEK_W'(HOME_MAX_STEPS);
   localparam logic [SEEK_W-1:0] SEEK_ONE  = SEEK_W'(1);
   localparam logic [POS_W-1:0]  POS_ONE   = POS_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEEK  = 2'd1,
      TRACK = 2'd2,
      FAULT = 2'd3
   } state_t;

   state_t            state_r, state_next_s;

   logic              nhome_meta_r, nhome_sync_r;
   logic              nflt_meta_r,  nflt_sync_r;
   logic              step_prev_r;
   logic              step_edge_s;

   logic              home_db_r;
   logic [DB_W-1:0]   db_cnt_r, db_cnt_next_s;
   logic              db_toggle_s;
   logic              home_rise_s;

   logic [SEEK_W-1:0] seek_cnt_r, seek_cnt_next_s;
   logic [POS_W-1:0]  pos_r, pos_next_s;
   logic              homed_r, homed_next_s;
   logic              home_done_r, home_done_next_s;
   logic              flt_r, flt_next_s;
   logic              home_to_r, home_to_next_s;

   // Input synchronizers and step history.
   // The synchronizers reset to the inactive (high) level so a reset never
   // looks like a fault or a closed home switch. The step history keeps
   // sampling during reset, so a step held high across reset is not
   // counted as a new edge on the first cycle afterwards.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         nhome_meta_r <= 1'b1;
         nhome_sync_r <= 1'b1;
         nflt_meta_r  <= 1'b1;
         nflt_sync_r  <= 1'b1;
      end else begin
         nhome_meta_r <= mtr_nhome;
         nhome_sync_r <= nhome_meta_r;
         nflt_meta_r  <= mtr_nflt;
         nflt_sync_r  <= nflt_meta_r;
      end
      step_prev_r <= mtr_step;
   end

   assign step_edge_s = mtr_step & ~step_prev_r;

   // Home debounce: count consecutive samples that disagree with the
   // current debounced level; flip on the DEBOUNCE-th one.
   always_comb begin
      db_toggle_s   = 1'b0;
      db_cnt_next_s = '0;
      // home_db high means switch closed (nhome low), so equality of the
      // two signals means the sample disagrees with the debounced level.
      if (nhome_sync_r == home_db_r) begin
         if (db_cnt_r == DB_LAST) begin
            db_toggle_s   = 1'b1;
            db_cnt_next_s = '0;
         end else begin
            db_toggle_s   = 1'b0;
            db_cnt_next_s = db_cnt_r + DB_ONE;
         end
      end else begin
         db_toggle_s   = 1'b0;
         db_cnt_next_s = '0;
      end
   end

   assign home_rise_s = db_toggle_s & ~home_db_r;

   // Debounce state registers.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         home_db_r <= 1'b0;
         db_cnt_r  <= '0;
      end else begin
         home_db_r <= home_db_r ^ db_toggle_s;
         db_cnt_r  <= db_cnt_next_s;
      end
   end

   // Next-state and next-output logic for the tracker FSM.
   always_comb begin
      state_next_s     = state_r;
      pos_next_s       = pos_r;
      homed_next_s     = homed_r;
      home_done_next_s = 1'b0;
      flt_next_s       = flt_r;
      home_to_next_s   = home_to_r;
      seek_cnt_next_s  = seek_cnt_r;

      if (step_edge_s && (state_r != FAULT)) begin
         if (mtr_dir) begin
            pos_next_s = pos_r - POS_ONE;
         end else begin
            pos_next_s = pos_r + POS_ONE;
         end
      end else begin
         pos_next_s = pos_r;
      end

      if (!nflt_sync_r) begin
         // Driver fault overrides every other event.
         state_next_s = FAULT;
         flt_next_s   = 1'b1;
         homed_next_s = 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (home_req) begin
                  state_next_s    = SEEK;
                  homed_next_s    = 1'b0;
                  seek_cnt_next_s = '0;
               end else begin
                  state_next_s = IDLE;
               end
            end
            SEEK: begin
               if (step_edge_s && (seek_cnt_r < SEEK_MAX)) begin
                  seek_cnt_next_s = seek_cnt_r + SEEK_ONE;
               end else begin
                  seek_cnt_next_s = seek_cnt_r;
               end
               if (home_rise_s) begin
                  // Zeroing wins over a coincident step edge.
                  state_next_s     = TRACK;
                  pos_next_s       = '0;
                  homed_next_s     = 1'b1;
                  home_done_next_s = 1'b1;
               end else if (seek_cnt_r >= SEEK_MAX) begin
                  state_next_s   = FAULT;
                  flt_next_s     = 1'b1;
                  home_to_next_s = 1'b1;
               end else begin
                  state_next_s = SEEK;
               end
            end
            TRACK: begin
               if (home_req) begin
                  state_next_s    = SEEK;
                  homed_next_s    = 1'b0;
                  seek_cnt_next_s = '0;
               end else begin
                  state_next_s = TRACK;
               end
            end
            FAULT: begin
               if (clr_flt) begin
                  state_next_s   = IDLE;
                  flt_next_s     = 1'b0;
                  home_to_next_s = 1'b0;
               end else begin
                  state_next_s = FAULT;
               end
            end
            default: begin
               state_next_s = IDLE;
            end
         endcase
      end
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk_100MHz) begin
      if (rst) begin
         state_r     <= IDLE;
         pos_r       <= '0;
         homed_r     <= 1'b0;
         home_done_r <= 1'b0;
         flt_r       <= 1'b0;
         home_to_r   <= 1'b0;
         seek_cnt_r  <= '0;
      end else begin
         state_r     <= state_next_s;
         pos_r       <= pos_next_s;
         homed_r     <= homed_next_s;
         home_done_r <= home_done_next_s;
         flt_r       <= flt_next_s;
         home_to_r   <= home_to_next_s;
         seek_cnt_r  <= seek_cnt_next_s;
      end
   end

   assign pos       = pos_r;
   assign homed     = homed_r;
   assign home_done = home_done_r;
   assign flt       = flt_r;
   assign home_to   = home_to_r;
   assign state     = state_r;

endmodule

// File: tb/tb_step_position_tracker.sv
// ---------------------------------------------------------------------------
// tb_step_position_tracker
//
// Directed testbench for step_position_tracker. A 24-bit instance with a
// short debounce and a 16-step homing limit exercises counting, homing,
// timeout, fault and reset; a 4-bit instance exercises positive wrap.
// ---------------------------------------------------------------------------
module tb_step_position_tracker;

   localparam int DEB = 8;

   logic        clk_100MHz = 1'b0;
   logic        rst        = 1'b1;
   logic        mtr_step   = 1'b0;
   logic        mtr_dir    = 1'b0;
   logic        mtr_nhome  = 1'b1;
   logic        mtr_nflt   = 1'b1;
   logic        home_req   = 1'b0;
   logic        clr_flt    = 1'b0;
   logic [23:0] pos;
   logic        homed, home_done, flt, home_to;
   logic [1:0]  state;

   logic        step2      = 1'b0;
   logic        dir2       = 1'b0;
   logic        one2       = 1'b1;
   logic        zero2      = 1'b0;
   logic [3:0]  pos2;
   logic        homed2, home_done2, flt2, home_to2;
   logic [1:0]  state2;

   int checks = 0;
   int errors = 0;

   always #5 clk_100MHz = ~clk_100MHz;

   step_position_tracker #(.POS_W(24), .DEBOUNCE(DEB), .HOME_MAX_STEPS(16)) dut (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .mtr_step   (mtr_step),
      .mtr_dir    (mtr_dir),
      .mtr_nhome  (mtr_nhome),
      .mtr_nflt   (mtr_nflt),
      .home_req   (home_req),
      .clr_flt    (clr_flt),
      .pos        (pos),
      .homed      (homed),
      .home_done  (home_done),
      .flt        (flt),
      .home_to    (home_to),
      .state      (state)
   );

   step_position_tracker #(.POS_W(4), .DEBOUNCE(DEB), .HOME_MAX_STEPS(16)) dut4 (
      .clk_100MHz (clk_100MHz),
      .rst        (rst),
      .mtr_step   (step2),
      .mtr_dir    (dir2),
      .mtr_nhome  (one2),
      .mtr_nflt   (one2),
      .home_req   (zero2),
      .clr_flt    (zero2),
      .pos        (pos2),
      .homed      (homed2),
      .home_done  (home_done2),
      .flt        (flt2),
      .home_to    (home_to2),
      .state      (state2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at a negedge with the step counted.
   task automatic do_step(input logic d);
      mtr_dir  = d;
      mtr_step = 1'b1;
      @(negedge clk_100MHz);
      mtr_step = 1'b0;
      @(negedge clk_100MHz);
   endtask

   task automatic do_step2(input logic d);
      dir2  = d;
      step2 = 1'b1;
      @(negedge clk_100MHz);
      step2 = 1'b0;
      @(negedge clk_100MHz);
   endtask

   task automatic pulse_home_req();
      home_req = 1'b1;
      @(negedge clk_100MHz);
      home_req = 1'b0;
   endtask

   task automatic pulse_clr_flt();
      clr_flt = 1'b1;
      @(negedge clk_100MHz);
      clr_flt = 1'b0;
   endtask

   initial begin
      int hd;
      int lat;

      // Reset
      repeat (2) @(negedge clk_100MHz);
      check("rst_pos",       pos,       32'h0);
      check("rst_state",     state,     32'h0);
      check("rst_homed",     homed,     32'h0);
      check("rst_home_done", home_done, 32'h0);
      check("rst_flt",       flt,       32'h0);
      check("rst_home_to",   home_to,   32'h0);
      rst = 1'b0;
      @(negedge clk_100MHz);

      // 5 up, 2 down
      repeat (5) do_step(1'b0);
      check("up5_pos", pos, 32'd5);
      repeat (2) do_step(1'b1);
      check("net3_pos",   pos,   32'd3);
      check("net3_state", state, 32'd0);
      check("net3_homed", homed, 32'd0);

      // Negative wrap
      repeat (3) do_step(1'b1);
      check("zero_pos", pos, 32'd0);
      do_step(1'b1);
      check("wrap_neg_pos", pos, 32'h00FF_FFFF);
      do_step(1'b0);
      check("unwrap_pos", pos, 32'd0);

      // Positive wrap on the 4-bit instance: max positive 7 -> min negative 8
      repeat (7) do_step2(1'b0);
      check("w4_max_pos", pos2, 32'h7);
      do_step2(1'b0);
      check("w4_wrap_pos", pos2, 32'h8);
      do_step2(1'b1);
      check("w4_back_pos", pos2, 32'h7);

      // Homing: steps count in SEEK, short home pulse rejected
      pulse_home_req();
      check("seek_state", state, 32'd1);
      check("seek_homed", homed, 32'd0);
      repeat (3) do_step(1'b0);
      check("seek_pos", pos, 32'd3);
      hd = 0;
      mtr_nhome = 1'b0;
      repeat (DEB - 1) begin
         @(negedge clk_100MHz);
         if (home_done) hd++;
      end
      mtr_nhome = 1'b1;
      repeat (DEB + 6) begin
         @(negedge clk_100MHz);
         if (home_done) hd++;
      end
      check("short_home_state", state, 32'd1);
      check("short_home_homed", homed, 32'd0);
      check("short_home_done",  hd,    32'd0);

      // Full home pulse
      mtr_nhome = 1'b0;
      repeat (DEB + 20) begin
         @(negedge clk_100MHz);
         if (home_done) hd++;
      end
      check("home_done_count", hd,    32'd1);
      check("home_state",      state, 32'd2);
      check("home_pos",        pos,   32'd0);
      check("home_homed",      homed, 32'd1);
      mtr_nhome = 1'b1;
      repeat (DEB + 6) @(negedge clk_100MHz);
      repeat (2) do_step(1'b0);
      check("track_pos",   pos,   32'd2);
      check("track_homed", homed, 32'd1);

      // Homing timeout after 16 steps
      pulse_home_req();
      check("reseek_state", state, 32'd1);
      check("reseek_homed", homed, 32'd0);
      repeat (15) do_step(1'b0);
      check("to15_state", state, 32'd1);
      check("to15_pos",   pos,   32'd17);
      do_step(1'b0);
      check("to_state",   state,   32'd3);
      check("to_flt",     flt,     32'd1);
      check("to_home_to", home_to, 32'd1);
      check("to_pos",     pos,     32'd18);
      do_step(1'b0);
      check("fault_step_pos", pos, 32'd18);
      pulse_clr_flt();
      check("clr_state",   state,   32'd0);
      check("clr_flt",     flt,     32'd0);
      check("clr_home_to", home_to, 32'd0);
      check("clr_pos",     pos,     32'd18);

      // Home again, then driver fault in TRACK
      pulse_home_req();
      mtr_nhome = 1'b0;
      repeat (DEB + 20) @(negedge clk_100MHz);
      mtr_nhome = 1'b1;
      check("rehome_state", state, 32'd2);
      repeat (DEB + 6) @(negedge clk_100MHz);
      do_step(1'b0);
      check("pre_flt_pos", pos, 32'd1);
      mtr_nflt = 1'b0;
      lat = 0;
      for (int i = 0; i < 3; i++) begin
         if (flt !== 1'b1) begin
            @(negedge clk_100MHz);
            lat++;
         end
      end
      check("nflt_flt",     flt,   32'd1);
      check("nflt_latency", (lat <= 3) ? 32'd1 : 32'd0, 32'd1);
      @(negedge clk_100MHz);
      check("nflt_state",   state, 32'd3);
      check("nflt_homed",   homed, 32'd0);
      do_step(1'b0);
      check("nflt_step_pos", pos, 32'd1);
      pulse_clr_flt();
      check("clr_low_state", state, 32'd3);
      check("clr_low_flt",   flt,   32'd1);
      mtr_nflt = 1'b1;
      repeat (3) @(negedge clk_100MHz);
      check("nflt_rel_state", state, 32'd3);
      pulse_clr_flt();
      check("clr_hi_state", state, 32'd0);
      check("clr_hi_flt",   flt,   32'd0);
      check("clr_hi_pos",   pos,   32'd1);

      // Reset mid-SEEK with a step edge in flight
      pulse_home_req();
      do_step(1'b0);
      check("mid_seek_pos", pos, 32'd2);
      mtr_dir  = 1'b0;
      mtr_step = 1'b1;
      rst      = 1'b1;
      @(negedge clk_100MHz);
      check("midrst_pos",       pos,       32'd0);
      check("midrst_state",     state,     32'd0);
      check("midrst_homed",     homed,     32'd0);
      check("midrst_home_done", home_done, 32'd0);
      check("midrst_flt",       flt,       32'd0);
      check("midrst_home_to",   home_to,   32'd0);
      rst = 1'b0;
      @(negedge clk_100MHz);
      check("post_rst_held_step_pos", pos, 32'd0);
      mtr_step = 1'b0;
      @(negedge clk_100MHz);
      do_step(1'b0);
      check("post_rst_step_pos", pos, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
